// File: rtl/heartbeat_generator.sv
// heartbeat_generator
//
// Producer side of the watchdog heartbeat link. Drives the heartbeat pulse
// consumed by watchdog_timer, but only while firmware proves it is alive by
// strobing sw_kick_i. Firmware that stops kicking (or, with the window check
// built in, kicks too fast) lands the block in STALLED, where beats stop and
// the watchdog is starved.
//
// Optional feature macro: HB_WINDOW_EN
//   defined   : a kick arriving while swCnt < WINDOW_MIN is an early/runaway
//               kick and stalls the block with fault code 2'b10.
//   undefined : every kick is accepted; WINDOW_MIN is unused.
//
// Ports
//   clk_i           system clock
//   rst_i           asynchronous, active-high reset
//   enable_i        block enable; low returns the block to IDLE
//   sw_kick_i       single-cycle software liveness strobe
//   wd_warning_i    watchdog warning level (rising edge requests an urgent beat)
//   wd_triggered_i  watchdog fired level (re-arms the block from ARMED/RUN)
//   heartbeat_o     heartbeat pulse to watchdog_timer
//   alive_o         high while in RUN
//   fault_o         sticky stall fault
//   fault_code_o    00 none, 01 software timeout, 10 early kick
//   beat_count_o    beats issued, wraps FFFF -> 0000

module heartbeat_generator #(
  parameter int unsigned PERIOD_CYCLES = 1_000_000,
  parameter int unsigned PULSE_CYCLES  = 1,
  parameter int unsigned SW_TIMEOUT    = 50_000_000,
  parameter int unsigned WINDOW_MIN    = 1_000_000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        sw_kick_i,
  input  logic        wd_warning_i,
  input  logic        wd_triggered_i,
  output logic        heartbeat_o,
  output logic        alive_o,
  output logic        fault_o,
  output logic [1:0]  fault_code_o,
  output logic [15:0] beat_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUN     = 2'd2,
    STALLED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_EXTRA = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_MIN     = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e            state_q, state_d;
  logic              warn_q;
  logic [CNT_W-1:0]  periodCnt_q, periodCnt_d;
  logic [CNT_W-1:0]  swCnt_q, swCnt_d;
  logic [CNT_W-1:0]  pulseRem_q, pulseRem_d;
  logic              heartbeat_q, heartbeat_d;
  logic              alive_q, alive_d;
  logic              fault_q, fault_d;
  logic [1:0]        faultCode_q, faultCode_d;
  logic [15:0]       beatCount_q, beatCount_d;

  logic warnEdge;
  logic swExpired;
  logic earlyKick;
  logic beatReq;

  // Event decode shared by the next-state and output logic. A kick in the
  // expiry cycle rescues firmware, so expiry requires the kick to be absent.
  assign warnEdge  = wd_warning_i & ~warn_q;
  assign swExpired = (swCnt_q == SW_LAST) & ~sw_kick_i;
  assign beatReq   = (periodCnt_q == PERIOD_LAST) | warnEdge;

`ifdef HB_WINDOW_EN
  assign earlyKick = sw_kick_i & (swCnt_q < WIN_MIN);
`else
  logic unusedWindow;
  assign unusedWindow = ^WIN_MIN;
  assign earlyKick    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. enable_i dominates everything; STALLED is only left
  // by dropping enable_i (or reset), and wd_triggered_i re-arms from ARMED/RUN.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ARMED;
        ARMED:   if (!wd_triggered_i && sw_kick_i) state_d = RUN;
        RUN: begin
          if (wd_triggered_i) begin
            state_d = ARMED;
          end else if (swExpired || earlyKick) begin
            state_d = STALLED;
          end
        end
        STALLED: state_d = STALLED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and counter next-values. Counters and the pulse only live while
  // staying in RUN; every other path clears them, which also truncates a
  // pulse on stall or re-arm. A beat request while a pulse is active simply
  // restarts the pulse width and still counts.
  always_comb begin
    periodCnt_d = '0;
    swCnt_d     = '0;
    pulseRem_d  = '0;
    heartbeat_d = 1'b0;
    alive_d     = (state_d == RUN);
    fault_d     = fault_q;
    faultCode_d = faultCode_q;
    beatCount_d = beatCount_q;

    if (!enable_i) begin
      fault_d     = 1'b0;
      faultCode_d = 2'b00;
    end else if (state_q == RUN && state_d == RUN) begin
      swCnt_d = sw_kick_i ? '0 : swCnt_q + CNT_ONE;
      if (beatReq) begin
        periodCnt_d = '0;
        heartbeat_d = 1'b1;
        pulseRem_d  = PULSE_EXTRA;
        beatCount_d = beatCount_q + 16'd1;
      end else begin
        periodCnt_d = periodCnt_q + CNT_ONE;
        if (heartbeat_q && pulseRem_q != '0) begin
          heartbeat_d = 1'b1;
          pulseRem_d  = pulseRem_q - CNT_ONE;
        end
      end
    end else if (state_q == RUN && state_d == STALLED) begin
      fault_d     = 1'b1;
      faultCode_d = swExpired ? 2'b01 : 2'b10;
    end
  end

  // Registered outputs, counters and the warning-edge history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      warn_q      <= 1'b0;
      periodCnt_q <= '0;
      swCnt_q     <= '0;
      pulseRem_q  <= '0;
      heartbeat_q <= 1'b0;
      alive_q     <= 1'b0;
      fault_q     <= 1'b0;
      faultCode_q <= 2'b00;
      beatCount_q <= '0;
    end else begin
      warn_q      <= wd_warning_i;
      periodCnt_q <= periodCnt_d;
      swCnt_q     <= swCnt_d;
      pulseRem_q  <= pulseRem_d;
      heartbeat_q <= heartbeat_d;
      alive_q     <= alive_d;
      fault_q     <= fault_d;
      faultCode_q <= faultCode_d;
      beatCount_q <= beatCount_d;
    end
  end

  assign heartbeat_o  = heartbeat_q;
  assign alive_o      = alive_q;
  assign fault_o      = fault_q;
  assign fault_code_o = faultCode_q;
  assign beat_count_o = beatCount_q;

endmodule

// File: tb/tb_heartbeat_generator.sv
// tb_heartbeat_generator
//
// Directed scenarios with hand-computed expectations followed by a long
// randomized run. A behavioural model tracks what the heartbeat producer
// must do each clock; a compare process checks every output against it on
// every falling edge.

module tb_heartbeat_generator;

  localparam int P  = 8;
  localparam int PW = 2;
  localparam int TO = 20;
  localparam int WM = 4;

`ifdef HB_WINDOW_EN
  localparam bit WIN_ON = 1'b1;
`else
  localparam bit WIN_ON = 1'b0;
`endif

  localparam int M_IDLE    = 0;
  localparam int M_ARMED   = 1;
  localparam int M_RUN     = 2;
  localparam int M_STALLED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        kick;
  logic        warn;
  logic        trig;
  logic        heartbeat;
  logic        alive;
  logic        fault;
  logic [1:0]  faultCode;
  logic [15:0] beatCount;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model state: mode, ages since last beat / last kick,
  // remaining high cycles of the heartbeat, total beats issued.
  int mMode;
  int mPeriod;
  int mSw;
  int mPulse;
  int mBeats;
  int mCode;
  bit mFault;
  bit mPrevWarn;

  heartbeat_generator #(
    .PERIOD_CYCLES(P),
    .PULSE_CYCLES (PW),
    .SW_TIMEOUT   (TO),
    .WINDOW_MIN   (WM),
    .CNT_W        (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .sw_kick_i     (kick),
    .wd_warning_i  (warn),
    .wd_triggered_i(trig),
    .heartbeat_o   (heartbeat),
    .alive_o       (alive),
    .fault_o       (fault),
    .fault_code_o  (faultCode),
    .beat_count_o  (beatCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock of the reference behaviour, straight from the block's rules.
  task automatic modelStep();
    bit warnRise;
    bit beat;
    if (rst) begin
      mMode = M_IDLE; mPeriod = 0; mSw = 0; mPulse = 0;
      mBeats = 0; mCode = 0; mFault = 0; mPrevWarn = 0;
    end else begin
      warnRise  = warn && !mPrevWarn;
      mPrevWarn = warn;
      if (!enable) begin
        mMode = M_IDLE; mPeriod = 0; mSw = 0; mPulse = 0;
        mFault = 0; mCode = 0;
      end else begin
        case (mMode)
          M_IDLE: mMode = M_ARMED;
          M_ARMED: begin
            if (!trig && kick) begin
              mMode = M_RUN; mPeriod = 0; mSw = 0;
            end
          end
          M_RUN: begin
            if (trig) begin
              mMode = M_ARMED; mPeriod = 0; mSw = 0; mPulse = 0;
            end else if (!kick && mSw == TO - 1) begin
              mMode = M_STALLED; mFault = 1; mCode = 1; mPulse = 0;
            end else if (WIN_ON && kick && mSw < WM) begin
              mMode = M_STALLED; mFault = 1; mCode = 2; mPulse = 0;
            end else begin
              beat = (mPeriod == P - 1) || warnRise;
              mSw  = kick ? 0 : mSw + 1;
              if (beat) begin
                mPeriod = 0;
                mPulse  = PW;
                mBeats  = (mBeats + 1) % 65536;
              end else begin
                mPeriod++;
                if (mPulse > 0) mPulse--;
              end
            end
          end
          default: mPulse = 0;
        endcase
      end
    end
  endtask

  always @(posedge clk or posedge rst) modelStep();

  // Every falling edge, all outputs against the model.
  always @(negedge clk) begin
    checkOutput("model_heartbeat", heartbeat, (mPulse > 0) ? 1 : 0);
    checkOutput("model_alive", alive, (mMode == M_RUN) ? 1 : 0);
    checkOutput("model_fault", fault, mFault);
    checkOutput("model_fault_code", faultCode, mCode);
    checkOutput("model_beat_count", beatCount, mBeats);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit k);
    kick = k;
    tick(1);
    kick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; kick = 1'b0; warn = 1'b0; trig = 1'b0;
    tick(2);
    checkOutput("reset_heartbeat", heartbeat, 0);
    checkOutput("reset_beat_count", beatCount, 0);
    checkOutput("reset_fault", fault, 0);
    rst = 1'b0;

    // Periodic beats after the first kick.
    enable = 1'b1;
    tick(2);
    applyStimulus(1'b1);
    checkOutput("kick_alive", alive, 1);
    tick(7);
    checkOutput("pre_beat_heartbeat", heartbeat, 0);
    tick(1);
    checkOutput("beat1_heartbeat", heartbeat, 1);
    checkOutput("beat1_count", beatCount, 1);
    tick(1);
    checkOutput("beat1_width2", heartbeat, 1);
    tick(1);
    checkOutput("beat1_end", heartbeat, 0);
    tick(1);
    applyStimulus(1'b1);
    tick(4);
    checkOutput("beat2_count", beatCount, 2);
    tick(8);
    checkOutput("beat3_count", beatCount, 3);
    checkOutput("beat3_heartbeat", heartbeat, 1);

    // Software timeout stalls; kicks ignored; enable low clears.
    tick(8);
    checkOutput("stall_fault", fault, 1);
    checkOutput("stall_code", faultCode, 1);
    checkOutput("stall_heartbeat", heartbeat, 0);
    checkOutput("stall_count", beatCount, 3);
    applyStimulus(1'b1);
    tick(3);
    checkOutput("stall_kick_ignored", alive, 0);
    checkOutput("stall_sticky", fault, 1);
    enable = 1'b0;
    tick(1);
    checkOutput("disable_fault", fault, 0);
    checkOutput("disable_count_kept", beatCount, 3);

    // Urgent beat on warning edge, then periodic from there.
    enable = 1'b1;
    tick(2);
    applyStimulus(1'b1);
    tick(3);
    warn = 1'b1;
    tick(1);
    checkOutput("urgent_heartbeat", heartbeat, 1);
    checkOutput("urgent_count", beatCount, 4);
    tick(7);
    checkOutput("urgent_held_no_beat", beatCount, 4);
    tick(1);
    checkOutput("after_urgent_beat", beatCount, 5);
    applyStimulus(1'b1);
    tick(7);
    checkOutput("warn_held_count", beatCount, 6);

    // Watchdog trigger re-arms.
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    checkOutput("trig_alive", alive, 0);
    tick(10);
    checkOutput("trig_no_beats", beatCount, 6);
    applyStimulus(1'b1);
    warn = 1'b0;
    checkOutput("rearm_alive", alive, 1);

    // Asynchronous reset mid-pulse.
    tick(8);
    checkOutput("pre_reset_heartbeat", heartbeat, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_heartbeat", heartbeat, 0);
    checkOutput("async_rst_count", beatCount, 0);
    tick(1);
    rst = 1'b0;

    // Kick spacing relative to the window.
    tick(2);
    applyStimulus(1'b1);
    tick(2);
    applyStimulus(1'b1);
`ifdef HB_WINDOW_EN
    checkOutput("early_kick_code", faultCode, 2);
    checkOutput("early_kick_alive", alive, 0);
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);
    applyStimulus(1'b1);
    tick(5);
    applyStimulus(1'b1);
    checkOutput("late_kick_alive", alive, 1);
    checkOutput("late_kick_code", faultCode, 0);
`else
    checkOutput("close_kick_alive", alive, 1);
    checkOutput("close_kick_code", faultCode, 0);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      rst    = ($urandom_range(999) == 0);
      enable = ($urandom_range(199) != 0);
      kick   = ($urandom_range(9) == 0);
      trig   = ($urandom_range(149) == 0);
      if ($urandom_range(29) == 0) warn = ~warn;
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
